// File: rtl/risc_datapath_if.sv
// Memory-side bus of the accumulator CPU datapath: address, write data and strobes, read data.
`timescale 1ns/1ps
interface risc_datapath_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_re;
    logic              mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_re,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_re,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/risc_datapath.sv
// Execution datapath of the 8-bit accumulator CPU: PC, IR, AC, ALU, zero flag, halt latch
// and the phase-driven memory address mux, all sequenced by the controller's strobes.
`timescale 1ns/1ps
module risc_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_rd,
    input  logic               load_ir,
    input  logic               halt,
    input  logic               inc_pc,
    input  logic               load_ac,
    input  logic               load_pc,
    input  logic               mem_wr,
    risc_datapath_if.master    mem,
    output logic [2:0]         opcode,
    output logic               zero,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  ac_out,
    output logic               halted
);
    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [2:0]        phase_q, phase_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] alu_res;
    opcode_e           op;

    assign op = opcode_e'(ir_q[DATA_W-1:ADDR_W]);

    always_comb begin
        alu_res = ac_q;
        case (op)
            OP_ADD:  alu_res = ac_q + mem.mem_rdata;
            OP_AND:  alu_res = ac_q & mem.mem_rdata;
            OP_XOR:  alu_res = ac_q ^ mem.mem_rdata;
            OP_LDA:  alu_res = mem.mem_rdata;
            default: alu_res = ac_q;
        endcase
    end

    always_comb begin
        // Phase runs free, even after halt, to stay aligned with the controller.
        phase_d  = phase_q + 3'd1;
        halted_d = halted_q | halt;
        ir_d     = ir_q;
        ac_d     = ac_q;
        pc_d     = pc_q;
        if (!halted_q) begin
            if (load_ir) ir_d = mem.mem_rdata;
            if (load_ac) ac_d = alu_res;
            if (load_pc) pc_d = ir_q[ADDR_W-1:0];
            else if (inc_pc) pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            phase_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // First half of the cycle fetches at PC, second half addresses the operand.
    assign mem.mem_addr  = phase_q[2] ? ir_q[ADDR_W-1:0] : pc_q;
    assign mem.mem_wdata = ac_q;
    assign mem.mem_re    = mem_rd;
    assign mem.mem_we    = mem_wr & ~halted_q;

    assign opcode = ir_q[DATA_W-1:ADDR_W];
    assign zero   = (ac_q == '0);
    assign pc_out = pc_q;
    assign ac_out = ac_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_risc_datapath.sv
// Bench for risc_datapath: an instruction-level CPU model drives the controller strobes and
// pushes expected state into queues that a negedge monitor compares against the DUT.
`timescale 1ns/1ps
module tb_risc_datapath;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_rd = 1'b0, load_ir = 1'b0, halt = 1'b0, inc_pc = 1'b0;
    logic       load_ac = 1'b0, load_pc = 1'b0, mem_wr = 1'b0;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] pc_out;
    logic [7:0] ac_out;
    logic       halted;

    risc_datapath_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    risc_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt),
        .inc_pc(inc_pc), .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
        .mem(bus), .opcode(opcode), .zero(zero), .pc_out(pc_out), .ac_out(ac_out),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT (written only through its write port) and the model's copy.
    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];
    assign bus.mem_rdata = mem[bus.mem_addr];

    typedef struct {
        int         cyc;
        logic [4:0] pc;
        logic [7:0] ac;
        logic [2:0] op;
        logic       hlt;
        logic [4:0] addr;
        logic       chk_re;
        logic       re;
    } snap_t;
    typedef struct {
        logic [4:0] wa;
        logic [7:0] wd;
    } wr_t;

    snap_t sq[$];
    wr_t   wq[$];

    int cyc = 0;
    int tb_phase = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [4:0] m_pc;
    logic [7:0] m_ac;
    logic [7:0] m_ir;
    logic       m_halted;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        logic       wv;
        logic [4:0] wa;
        logic [7:0] wd;
        @(negedge clk);
        wv = bus.mem_we;
        wa = bus.mem_addr;
        wd = bus.mem_wdata;
        @(posedge clk);
        #1;
        if (wv === 1'b1) mem[wa] = wd;
    endtask

    task automatic push_snap(input int c, input int ph, input logic chk_re, input logic re);
        snap_t s;
        s.cyc    = c;
        s.pc     = m_pc;
        s.ac     = m_ac;
        s.op     = m_ir[7:5];
        s.hlt    = m_halted;
        s.addr   = (ph < 4) ? m_pc : m_ir[4:0];
        s.chk_re = chk_re;
        s.re     = re;
        sq.push_back(s);
    endtask

    task automatic clear_strobes();
        {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_strobes();
        tick();
        rst = 1'b0;
        m_pc = '0; m_ac = '0; m_ir = '0; m_halted = 1'b0;
        tb_phase = 0;
        push_snap(cyc, 0, 1'b0, 1'b0);
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) poke(i, 8'h00);
    endtask

    // The sequence controller's strobe pattern for one phase of an instruction.
    task automatic drive_phase(input int p, input logic [2:0] op, input logic zb);
        logic alu;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        tb_phase = p;
        mem_rd   = (p >= 1 && p <= 3) || (p >= 5 && alu);
        load_ir  = (p == 2) || (p == 3);
        inc_pc   = (p == 4) || (p == 6 && op == 3'd1 && zb);
        halt     = (p == 4) && (op == 3'd0);
        load_pc  = (p >= 6) && (op == 3'd7);
        load_ac  = (p == 7) && alu;
        mem_wr   = (p == 7) && (op == 3'd6);
        tick();
    endtask

    task automatic run_instr();
        logic [7:0] iw, b;
        logic [2:0] op;
        logic [4:0] a;
        logic       zb;
        int         c0;
        wr_t        w;
        iw = ref_mem[m_pc];
        op = iw[7:5];
        a  = iw[4:0];
        b  = ref_mem[a];
        zb = (m_ac == 8'h00);
        c0 = cyc;
        m_ir = iw;
        m_pc = m_pc + 5'd1;
        case (op)
            3'd0: m_halted = 1'b1;
            3'd1: if (zb) m_pc = m_pc + 5'd1;
            3'd2: m_ac = m_ac + b;
            3'd3: m_ac = m_ac & b;
            3'd4: m_ac = m_ac ^ b;
            3'd5: m_ac = b;
            3'd6: begin
                ref_mem[a] = m_ac;
                w.wa = a;
                w.wd = m_ac;
                wq.push_back(w);
            end
            default: m_pc = a;
        endcase
        push_snap(c0 + 8, 0, 1'b0, 1'b0);
        for (int p = 0; p < 8; p++) drive_phase(p, op, zb);
        tb_phase = 0;
        clear_strobes();
    endtask

    task automatic run_partial(input int n);
        logic [7:0] iw;
        iw = ref_mem[m_pc];
        for (int p = 0; p < n; p++) drive_phase(p, iw[7:5], m_ac == 8'h00);
    endtask

    // While halted, hammer the datapath with random strobes; state must stay frozen.
    task automatic halted_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = 7'($urandom);
            if (i % 2 == 0) begin
                load_ac = 1'b1; load_pc = 1'b1; mem_wr = 1'b1; load_ir = 1'b1;
            end
            push_snap(cyc, tb_phase, 1'b1, mem_rd);
            tick();
            tb_phase = (tb_phase + 1) % 8;
        end
        clear_strobes();
    endtask

    task automatic check_mem();
        for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));
    endtask

    // Monitor: write port and end-of-instruction state, decoupled from stimulus.
    initial begin
        snap_t s;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: mem_we=1 addr=%0d data=%0h, expected mem_we=0",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(w.wa));
                    chk("wr_data", 32'(bus.mem_wdata), 32'(w.wd));
                    chk("wr_phase", 32'(tb_phase), 32'd7);
                end
            end
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                s = sq.pop_front();
                if (s.cyc < cyc) begin
                    n_checks++;
                    $display("FAIL missed_snapshot: at cycle %0d, expected cycle %0d", cyc, s.cyc);
                end else begin
                    chk("pc",     32'(pc_out),       32'(s.pc));
                    chk("ac",     32'(ac_out),       32'(s.ac));
                    chk("opcode", 32'(opcode),       32'(s.op));
                    chk("halted", 32'(halted),       32'(s.hlt));
                    chk("zero",   32'(zero),         32'(s.ac == 8'h00));
                    chk("addr",   32'(bus.mem_addr), 32'(s.addr));
                    if (s.chk_re) chk("mem_re", 32'(bus.mem_re), 32'(s.re));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // LDA 5
        clear_mem();
        do_reset();
        poke(0, 8'hA5); poke(5, 8'h3C);
        run_instr();

        // LDA 5; ADD 6 (carry dropped); XOR 5
        do_reset();
        clear_mem();
        poke(0, 8'hA5); poke(1, 8'h46); poke(2, 8'h85); poke(5, 8'hF0); poke(6, 8'h20);
        repeat (3) run_instr();

        // SKZ taken, then not taken
        do_reset();
        clear_mem();
        poke(0, 8'hA7); poke(1, 8'h20); poke(2, 8'hE3); poke(7, 8'h00);
        repeat (2) run_instr();
        do_reset();
        poke(7, 8'h01);
        repeat (3) run_instr();

        // LDA 5; STO 9
        do_reset();
        clear_mem();
        poke(0, 8'hA5); poke(1, 8'hC9); poke(5, 8'h77);
        repeat (2) run_instr();
        check_mem();

        // JMP 31, fall-through wraps PC to 0
        do_reset();
        clear_mem();
        poke(0, 8'hFF); poke(31, 8'hA0);
        repeat (2) run_instr();

        // HLT at address 2, then forced strobes while halted, then reset
        do_reset();
        clear_mem();
        poke(0, 8'hA5); poke(1, 8'h45); poke(2, 8'h00); poke(5, 8'h11);
        repeat (3) run_instr();
        halted_cycles(16);
        do_reset();

        // Reset in the middle of an instruction restarts cleanly at phase 0
        clear_mem();
        poke(0, 8'hA5); poke(1, 8'h46); poke(5, 8'h0F); poke(6, 8'h01);
        run_instr();
        run_partial(5);
        do_reset();
        repeat (2) run_instr();

        // Random programs
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 32; i++) poke(i, 8'($urandom));
            for (int k = 0; k < 40; k++) begin
                run_instr();
                if (m_halted) break;
            end
            if (m_halted) halted_cycles(8);
            tick();
            check_mem();
        end

        clear_strobes();
        tick();
        tick();
        if (sq.size() != 0) begin
            n_checks++;
            $display("FAIL pending_snapshots: %0d left, expected 0", sq.size());
        end
        if (wq.size() != 0) begin
            n_checks++;
            $display("FAIL missing_writes: %0d left, expected 0", wq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/risc_datapath.md
# risc_datapath

Execution datapath for the 8-bit accumulator CPU. It holds the program counter, instruction register, accumulator, ALU, zero flag and halt latch. It is driven cycle-by-cycle by the sequence controller's strobes (mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr) and returns the opcode and zero flag the controller decodes. It also owns the address/data side of the single-port program/data memory.

## Interface
- DATA_W, 8, instruction/data width; must equal ADDR_W+3
- ADDR_W, 5, memory address width (32 words)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset; released on the same edge as the controller reset
- mem_rd  input  1  controller read strobe
- load_ir  input  1  load IR from mem_rdata
- halt  input  1  controller halt request
- inc_pc  input  1  PC increment
- load_ac  input  1  load AC from ALU result
- load_pc  input  1  load PC from IR operand
- mem_wr  input  1  controller write strobe
- mem_rdata  input  DATA_W  memory read data, combinational from mem_addr
- opcode  output  3  IR[DATA_W-1:ADDR_W] to controller
- zero  output  1  1 when AC==0 (combinational)
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  always AC
- mem_re  output  1  = mem_rd
- mem_we  output  1  = mem_wr & ~halted
- pc_out, ac_out  output  ADDR_W, DATA_W  debug views of PC, AC
- halted  output  1  halt latch

## Operation
- Instruction word: [7:5] opcode, [4:0] operand address. Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- Phase counter: 3-bit, reset 0, +1 every cycle, wraps 7->0. It runs in lockstep with the controller's 8-state cycle and is never gated, including after halt.
- Address mux: mem_addr = PC for phase 0-3; mem_addr = IR[4:0] for phase 4-7.
- ALU on the opcode of the current IR, with mem_rdata as operand B:
  - ADD: AC+B, mod 2^8, carry dropped
  - AND: AC&B
  - XOR: AC^B
  - LDA: B
  - any other opcode: AC, unchanged
- Register updates, only when halted==0:
  - IR <= mem_rdata if load_ir
  - AC <= ALU result if load_ac
  - PC: load_pc has priority, so PC <= IR[4:0]; otherwise if inc_pc then PC <= PC+1, wrapping 31->0
- Halt: halted <= 1 on any edge with halt==1. It is sticky until rst. The PC increment requested on that same edge still takes effect.
- While halted, IR, AC and PC are frozen and mem_we is forced to 0. mem_re still follows mem_rd.

## Timing
- Reset values:
  - PC=0, IR=0 (opcode=000), AC=0, phase=0, halted=0
  - zero=1, mem_addr=0, mem_we=0, mem_re=0 (as long as the controller's strobes are low)
- All loads take effect on the edge that samples the strobe; the new value is visible the following cycle.
- mem_rdata is sampled on the same edge it is used. Memory is combinational-read, so there is no read latency.
- Write: mem_we is asserted during phase 7 for STO. Memory captures mem_wdata=AC at mem_addr=IR operand on that edge.
- IR is loaded in phases 2 and 3 with identical data.
- JMP asserts load_pc in phases 6 and 7; both load the same value.
- SKZ: the controller raises inc_pc in phase 6 only if zero=1. The datapath applies it unconditionally.
- Reset mid-instruction: all state returns to reset values on that edge and the phase restarts at 0.

## Test plan
- Reset, then mem[0]=0xA5 (LDA 5), mem[5]=0x3C: at the end of phase 7, AC=0x3C, PC=1, zero=0.
- LDA 5; ADD 6 with mem[5]=0xF0, mem[6]=0x20: AC=0x10 (carry dropped). Then XOR 5: AC=0xE0.
- LDA 7 with mem[7]=0x00, then SKZ, then JMP 3: PC after SKZ=3 (skip taken). Repeat with mem[7]=0x01: PC=2.
- LDA 5 with mem[5]=0x77, then STO 9: mem_we is high for exactly one cycle (phase 7), mem_addr=9, mem_wdata=0x77, mem[9]=0x77.
- JMP 31 at PC=0, then an instruction at 31 that falls through: PC 31 wraps to 0 on the next increment.
- HLT at address 2: halted=1, PC=3. Over 16 further cycles with forced load_ac/load_pc/mem_wr strobes, AC/PC/IR are unchanged and mem_we=0. rst clears halted and PC to 0.
